mproc_ctrl_p: RTL

- Parametrised multi-cycle control unit for the next-generation mproc datapath.
- Drives the PC, IR, register file/ALU (reg_alu) and a memory port with a request/ready handshake.
- Adds over the previous control logic: variable-latency memory (wait states), a STORE class, a conditional jump on a selectable flag, and configurable instruction/address widths.
- Sits between the IR output (cur_ins) and the pc / ir / reg_alu enables.

---
 rtl/mproc_pkg.sv | 20 ++
 rtl/mproc_ctrl_state.sv | 23 ++
 rtl/mproc_ctrl_p.sv | 61 ++++++
 3 files changed

// File: rtl/mproc_pkg.sv
// mproc_pkg: shared state encodings, instruction classes and default widths for the mproc control unit
package mproc_pkg;
  localparam int IW_D  = 16;
  localparam int RAW_D = 3;
  localparam int OPW_D = 2;
  localparam int AW_D  = 7;
  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;
  typedef enum logic [1:0] {
    CLS_ALU   = 2'b00,
    CLS_JMP   = 2'b01,
    CLS_LOAD  = 2'b10,
    CLS_STORE = 2'b11
  } cls_t;
endpackage

// File: rtl/mproc_ctrl_state.sv
// mproc_ctrl_state: state register and next-state logic of the mproc control unit
module mproc_ctrl_state
  import mproc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] cls,
  input  logic       mem_ready,
  output state_t     state
);
  state_t nxt;
  always_comb begin
    nxt = FETCH;
    case (state)
      FETCH:   nxt = mem_ready ? DECODE : FETCH;
      DECODE:  nxt = cls[1] ? MEM : EXEC;
      MEM:     nxt = !mem_ready ? MEM : (cls == CLS_STORE) ? FETCH : WB;
      default: nxt = FETCH;
    endcase
  end
  always_ff @(posedge clk)
    state <= !reset ? FETCH : nxt;
endmodule

// File: rtl/mproc_ctrl_p.sv
// mproc_ctrl_p: multi-cycle control unit driving pc, ir, reg_alu and a wait-state memory port
module mproc_ctrl_p
  import mproc_pkg::*;
#(
  parameter int IW  = IW_D,
  parameter int RAW = RAW_D,
  parameter int OPW = OPW_D,
  parameter int AW  = AW_D
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [IW-1:0]  cur_ins,
  input  logic           cout,
  input  logic           zero,
  input  logic           mem_ready,
  output logic [RAW-1:0] rd_addr_a,
  output logic [RAW-1:0] rd_addr_b,
  output logic [RAW-1:0] wr_addr,
  output logic [OPW-1:0] op,
  output logic [AW-1:0]  jump_addr,
  output logic           sel,
  output logic           jump,
  output logic           pc_inc,
  output logic           load_ir,
  output logic           wr_reg,
  output logic           mem_req,
  output logic           mem_we,
  output logic           addr_sel
);
  state_t state;
  cls_t   cls;
  logic   taken;
  logic   unused_ok;
  assign cls       = cls_t'(cur_ins[IW-1:IW-2]);
  assign taken     = cur_ins[IW-3] ? zero : cout;
  assign rd_addr_a = cur_ins[RAW-1:0];
  assign rd_addr_b = cur_ins[2*RAW-1:RAW];
  assign wr_addr   = cur_ins[3*RAW-1:2*RAW];
  assign op        = cur_ins[3*RAW+OPW-1:3*RAW];
  assign jump_addr = cur_ins[AW-1:0];
  assign unused_ok = ^cur_ins;
  mproc_ctrl_state u_state (
    .clk      (clk),
    .reset    (reset),
    .cls      (cur_ins[IW-1:IW-2]),
    .mem_ready(mem_ready),
    .state    (state)
  );
  // Strobes are forced off combinationally while reset is low so an aborted
  // instruction cannot write back or redirect the PC in the reset cycle.
  always_comb begin
    mem_req  = reset && (state == FETCH || state == MEM);
    mem_we   = reset && state == MEM && cls == CLS_STORE;
    addr_sel = reset && (state == MEM || state == WB);
    load_ir  = reset && state == FETCH && mem_ready;
    pc_inc   = reset && state == FETCH && mem_ready;
    wr_reg   = reset && ((state == EXEC && cls == CLS_ALU) || state == WB);
    jump     = reset && state == EXEC && cls == CLS_JMP && taken;
    sel      = !(reset && state == WB);
  end
endmodule
